// File: rtl/predicate_predictor_pkg.sv
// Shared helpers for the predicate predictor bank: counter reset value,
// saturating counter arithmetic and a population count.
package predicate_predictor_pkg;

    // Widest misprediction vector the popcount helper accepts.
    localparam int unsigned POPCOUNT_MAX_W = 64;

    // "Weakly 0" starting point: 2^(width-1)-1, which is 0 for width 1.
    function automatic logic [31:0] counter_reset_value(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] counter_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        return (value >= counter_max(width)) ? value : value + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] value);
        return (value == 32'd0) ? 32'd0 : value - 32'd1;
    endfunction

    function automatic logic [31:0] popcount(input logic [POPCOUNT_MAX_W-1:0] vec);
        logic [31:0] total;
        total = 32'd0;
        for (int unsigned k = 0; k < POPCOUNT_MAX_W; k++) begin
            total = total + 32'(vec[k]);
        end
        return total;
    endfunction

endpackage

// File: rtl/predicate_predictor_entry.sv
// One predictor entry: saturating confidence counter(s), the prediction bit
// and the combinational misprediction detect for this cycle's write-back.
// With PREDICATE_PREDICTOR_LOCAL_HISTORY_EN defined, the entry keeps a local
// outcome history that selects one of 2^HISTORY_WIDTH counters.
module predicate_predictor_entry
    import predicate_predictor_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 2,
    parameter int unsigned HISTORY_WIDTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic write_i,
    input  logic observed_i,
    output logic prediction_o,
    output logic mispredict_o
);

`ifdef PREDICATE_PREDICTOR_LOCAL_HISTORY_EN
    localparam int unsigned NUM_CTRS = 1 << HISTORY_WIDTH;
`else
    localparam int unsigned NUM_CTRS = 1;
`endif

    localparam logic [COUNTER_WIDTH-1:0] CTR_RESET =
        COUNTER_WIDTH'(counter_reset_value(COUNTER_WIDTH));

    logic [COUNTER_WIDTH-1:0] ctr_q [NUM_CTRS];
    logic [COUNTER_WIDTH-1:0] ctr_d [NUM_CTRS];
    logic [COUNTER_WIDTH-1:0] sel_ctr;
    logic [COUNTER_WIDTH-1:0] trained_ctr;
    int unsigned              sel_idx;
    logic                     update;

    assign update = enable && write_i;

`ifdef PREDICATE_PREDICTOR_LOCAL_HISTORY_EN
    logic [HISTORY_WIDTH-1:0] hist_q;
    logic [HISTORY_WIDTH-1:0] hist_d;
    logic [HISTORY_WIDTH:0]   hist_shift;

    assign sel_idx    = 32'(hist_q);
    assign sel_ctr    = ctr_q[hist_q];
    assign hist_shift = {hist_q, observed_i};
    assign hist_d     = update ? hist_shift[HISTORY_WIDTH-1:0] : hist_q;

    // Local outcome history: newest outcome enters at the LSB.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign sel_idx = 0;
    assign sel_ctr = ctr_q[0];
`endif

    // Prediction and mispredict detect both use the pre-update counter.
    assign prediction_o = sel_ctr[COUNTER_WIDTH-1];
    assign mispredict_o = update && (observed_i != prediction_o);
    assign trained_ctr  = observed_i ? COUNTER_WIDTH'(sat_inc(32'(sel_ctr), COUNTER_WIDTH))
                                     : COUNTER_WIDTH'(sat_dec(32'(sel_ctr)));

    // Train only the counter selected before this update.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CTRS; k++) begin
            ctr_d[k] = (update && (k == sel_idx)) ? trained_ctr : ctr_q[k];
        end
    end

    // Counter state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_CTRS; k++) begin
                ctr_q[k] <= CTR_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/predicate_predictor_bank.sv
// Bank of per-predicate saturating-counter predictors with registered
// per-predicate misprediction flags and a saturating misprediction counter.
// Optional local-history mode: define PREDICATE_PREDICTOR_LOCAL_HISTORY_EN.
// NUM_PREDICATES is limited to the popcount helper width (64).
module predicate_predictor_bank
    import predicate_predictor_pkg::*;
#(
    parameter int unsigned NUM_PREDICATES = 8,
    parameter int unsigned COUNTER_WIDTH  = 2,
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned HISTORY_WIDTH  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_PREDICATES-1:0] datapath_write,
    input  logic [NUM_PREDICATES-1:0] observed_values,
    input  logic                      clear_count,
    output logic [NUM_PREDICATES-1:0] predictions,
    output logic [NUM_PREDICATES-1:0] mispredict,
    output logic [COUNT_WIDTH-1:0]    mispredict_count
);

    localparam int unsigned SUM_W = COUNT_WIDTH + $clog2(NUM_PREDICATES + 1);
    localparam logic [SUM_W-1:0] COUNT_MAX = SUM_W'({COUNT_WIDTH{1'b1}});

    logic [NUM_PREDICATES-1:0] mispredict_d;
    logic [NUM_PREDICATES-1:0] mispredict_q;
    logic [COUNT_WIDTH-1:0]    count_d;
    logic [COUNT_WIDTH-1:0]    count_q;
    logic [SUM_W-1:0]          count_sum;

    for (genvar g = 0; g < NUM_PREDICATES; g++) begin : g_entry
        predicate_predictor_entry #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .HISTORY_WIDTH (HISTORY_WIDTH)
        ) u_entry (
            .clock        (clock),
            .reset        (reset),
            .enable       (enable),
            .write_i      (datapath_write[g]),
            .observed_i   (observed_values[g]),
            .prediction_o (predictions[g]),
            .mispredict_o (mispredict_d[g])
        );
    end

    // Wide sum so the clamp sees the true total before saturating.
    assign count_sum = SUM_W'(count_q)
                     + SUM_W'(popcount(POPCOUNT_MAX_W'(mispredict_d)));

    // Statistics next state: clear beats increments and ignores enable.
    always_comb begin
        count_d = count_q;
        if (clear_count) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_sum > COUNT_MAX) ? {COUNT_WIDTH{1'b1}}
                                              : count_sum[COUNT_WIDTH-1:0];
        end
    end

    // Mispredict flags and statistics counter, aligned on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict_q <= '0;
            count_q      <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            count_q      <= count_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_predicate_predictor_bank.sv
// Self-checking bench for predicate_predictor_bank: directed vector table,
// multi-cycle history sequence (when PREDICATE_PREDICTOR_LOCAL_HISTORY_EN is
// defined) and randomized traffic against a behavioural model.
module tb_predicate_predictor_bank;

    localparam int NP   = 8;
    localparam int CW   = 2;
    localparam int CNTW = 4;
    localparam int HW   = 2;
`ifdef PREDICATE_PREDICTOR_LOCAL_HISTORY_EN
    localparam int NCTR = 1 << HW;
`else
    localparam int NCTR = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NP-1:0]   wr;
    logic [NP-1:0]   obs;
    logic            clr;
    logic [NP-1:0]   preds;
    logic [NP-1:0]   mp;
    logic [CNTW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    predicate_predictor_bank #(
        .NUM_PREDICATES (NP),
        .COUNTER_WIDTH  (CW),
        .COUNT_WIDTH    (CNTW),
        .HISTORY_WIDTH  (HW)
    ) dut (
        .clock            (clk),
        .reset            (rst),
        .enable           (en),
        .datapath_write   (wr),
        .observed_values  (obs),
        .clear_count      (clr),
        .predictions      (preds),
        .mispredict       (mp),
        .mispredict_count (cnt)
    );

    // Behavioural model: plain integer counters, history and totals.
    int            m_ctr [NP][NCTR];
    int            m_hist [NP];
    int            m_cnt;
    logic [NP-1:0] m_mp;

    function automatic logic m_pred_bit(int i);
        int idx;
        idx = (NCTR > 1) ? m_hist[i] : 0;
        return (m_ctr[i][idx] >= (1 << (CW - 1)));
    endfunction

    function automatic logic [NP-1:0] m_preds();
        logic [NP-1:0] p;
        for (int i = 0; i < NP; i++) p[i] = m_pred_bit(i);
        return p;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NP; i++) begin
            for (int j = 0; j < NCTR; j++) m_ctr[i][j] = (1 << (CW - 1)) - 1;
            m_hist[i] = 0;
        end
        m_cnt = 0;
        m_mp  = '0;
    endtask

    task automatic m_step(logic [NP-1:0] w, logic [NP-1:0] o, logic e, logic c, logic r);
        int n;
        int idx;
        logic [NP-1:0] newmp;
        if (r) begin
            m_reset();
        end else begin
            n = 0;
            newmp = '0;
            for (int i = 0; i < NP; i++) begin
                if (e && w[i]) begin
                    idx = (NCTR > 1) ? m_hist[i] : 0;
                    if (o[i] != m_pred_bit(i)) begin
                        newmp[i] = 1'b1;
                        n++;
                    end
                    if (o[i]) m_ctr[i][idx] = (m_ctr[i][idx] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_ctr[i][idx] + 1;
                    else      m_ctr[i][idx] = (m_ctr[i][idx] == 0) ? 0 : m_ctr[i][idx] - 1;
                    m_hist[i] = ((m_hist[i] << 1) | int'(o[i])) & (NCTR - 1);
                end
            end
            if (c)      m_cnt = 0;
            else if (e) m_cnt = (m_cnt + n > (1 << CNTW) - 1) ? (1 << CNTW) - 1 : m_cnt + n;
            m_mp = newmp;
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample after the edge.
    task automatic drive(logic [NP-1:0] w, logic [NP-1:0] o, logic e, logic c, logic r);
        @(negedge clk);
        wr  = w;
        obs = o;
        en  = e;
        clr = c;
        rst = r;
        m_step(w, o, e, c, r);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NP-1:0] w;
        logic [NP-1:0] o;
        logic          e;
        logic          c;
        logic          r;
        logic [NP-1:0] pred;
        logic [NP-1:0] mpx;
        int            cntx;
    } vec_t;

    vec_t tbl [25];

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        wr  = '0;
        obs = '0;
        clr = 1'b0;
        m_reset();

`ifndef PREDICATE_PREDICTOR_LOCAL_HISTORY_EN
        //            wr     obs    en    clr   rst    pred   mp     cnt
        tbl[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0};
        tbl[1]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 0};
        tbl[2]  = '{8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1};
        tbl[3]  = '{8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 8'h09, 8'h08, 2};
        tbl[4]  = '{8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 8'h09, 8'h00, 2};
        tbl[5]  = '{8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 8'h09, 8'h00, 2};
        tbl[6]  = '{8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 8'h09, 8'h00, 2};
        tbl[7]  = '{8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 8'h09, 8'h08, 3};
        tbl[8]  = '{8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 8'h08, 4};
        tbl[9]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 0};
        tbl[10] = '{8'h07, 8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 8'h07, 3};
        tbl[11] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 3};
        tbl[12] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 3};
        tbl[13] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h07, 8'h00, 0};
        tbl[14] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 3};
        tbl[15] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h07, 8'hFF, 11};
        tbl[16] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 14};
        tbl[17] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h07, 8'hFF, 15};
        tbl[18] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 15};
        tbl[19] = '{8'h01, 8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 0};
        tbl[20] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1};
        tbl[21] = '{8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 2};
        tbl[22] = '{8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 2};
        tbl[23] = '{8'h02, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 0};
        tbl[24] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 0};

        for (int r = 0; r < 25; r++) begin
            drive(tbl[r].w, tbl[r].o, tbl[r].e, tbl[r].c, tbl[r].r);
            check($sformatf("row%0d predictions", r), int'(preds), int'(tbl[r].pred));
            check($sformatf("row%0d mispredict", r), int'(mp), int'(tbl[r].mpx));
            check($sformatf("row%0d count", r), int'(cnt), tbl[r].cntx);
        end
`else
        // Alternating 1,0,1,0 on predicate 2: history learns the pattern.
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        check("hist reset predictions", int'(preds), 0);
        check("hist reset count", int'(cnt), 0);
        for (int k = 0; k < 12; k++) begin
            logic bitv;
            bitv = ((k % 2) == 0);
            drive(8'h04, {5'b0, bitv, 2'b0}, 1'b1, 1'b0, 1'b0);
            if (k >= 4) begin
                check($sformatf("hist step%0d mispredict2", k), int'(mp[2]), 0);
                check($sformatf("hist step%0d prediction2", k), int'(preds[2]), int'(!bitv));
            end
            check($sformatf("hist step%0d model preds", k), int'(preds), int'(m_preds()));
        end
        check("hist warmup count", int'(cnt), 2);
`endif

        // Randomized traffic against the model.
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            logic [NP-1:0] rw;
            logic [NP-1:0] ro;
            logic re;
            logic rc;
            logic rr;
            rw = NP'($urandom);
            ro = NP'($urandom);
            re = ($urandom_range(0, 9) < 8);
            rc = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 49) == 0);
            drive(rw, ro, re, rc, rr);
            check($sformatf("rand%0d predictions", n), int'(preds), int'(m_preds()));
            check($sformatf("rand%0d mispredict", n), int'(mp), int'(m_mp));
            check($sformatf("rand%0d count", n), int'(cnt), m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
